// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants and types.
// Sizes of the pool1 -> conv2 handoff.
package cnn_pkg;

  localparam int POOL1_OUT_W = 12;
  localparam int POOL1_OUT_H = 12;
  localparam int POOL1_BIT   = 14;
  localparam int CONV2_K     = 3;
  localparam int CONV2_OUT   = 10;

  typedef logic [POOL1_BIT-1:0] pix_t;

endpackage

// File: rtl/conv2_line_buf.sv
// Two-row line buffer for one channel.
// Column-indexed, read-before-write.
module conv2_line_buf
  import cnn_pkg::*;
#(
  parameter int DATA_BIT = POOL1_BIT,
  parameter int IMG_W    = POOL1_OUT_W,
  parameter int CNT_BIT  = 4
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [CNT_BIT-1:0]  col_i,
  input  logic [DATA_BIT-1:0] pix_i,
  output logic [DATA_BIT-1:0] row0_o,
  output logic [DATA_BIT-1:0] row1_o
);

  // Contents are masked downstream until two full rows exist.
  logic [DATA_BIT-1:0] lb0_q [IMG_W];
  logic [DATA_BIT-1:0] lb1_q [IMG_W];

  assign row0_o = lb0_q[col_i];
  assign row1_o = lb1_q[col_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      lb1_q[col_i] <= lb0_q[col_i];
      lb0_q[col_i] <= pix_i;
    end
  end

endmodule

// File: rtl/conv2_window_gen.sv
// 3x3 stride-1 window generator for conv2.
// Three channels share counters and valid/last.
module conv2_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_BIT = POOL1_BIT,
  parameter int IMG_W    = POOL1_OUT_W,
  parameter int IMG_H    = POOL1_OUT_H,
  parameter int K        = CONV2_K,
  parameter int CNT_BIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_BIT-1:0]   pix_1,
  input  logic [DATA_BIT-1:0]   pix_2,
  input  logic [DATA_BIT-1:0]   pix_3,
  output logic [9*DATA_BIT-1:0] win_1,
  output logic [9*DATA_BIT-1:0] win_2,
  output logic [9*DATA_BIT-1:0] win_3,
  output logic                  valid_out,
  output logic                  last_out
);

  localparam int KK = K * K;
  localparam logic [CNT_BIT-1:0] COL_MAX = CNT_BIT'(IMG_W - 1);
  localparam logic [CNT_BIT-1:0] ROW_MAX = CNT_BIT'(IMG_H - 1);
  localparam logic [CNT_BIT-1:0] EDGE    = CNT_BIT'(K - 1);

  logic [CNT_BIT-1:0] col_q, col_d;
  logic [CNT_BIT-1:0] row_q, row_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic [2:0][DATA_BIT-1:0] pix;
  logic [2:0][DATA_BIT-1:0] lb0;
  logic [2:0][DATA_BIT-1:0] lb1;
  logic [2:0][KK-1:0][DATA_BIT-1:0] win_q, win_d;

  assign pix = {pix_3, pix_2, pix_1};

  for (genvar ch = 0; ch < 3; ch++) begin : g_lb
    conv2_line_buf #(
      .DATA_BIT (DATA_BIT),
      .IMG_W    (IMG_W),
      .CNT_BIT  (CNT_BIT)
    ) u_lb (
      .clk    (clk),
      .we_i   (valid_in),
      .col_i  (col_q),
      .pix_i  (pix[ch]),
      .row0_o (lb0[ch]),
      .row1_o (lb1[ch])
    );
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (valid_in) begin
      valid_d = (row_q >= EDGE) && (col_q >= EDGE);
      last_d  = valid_d && (row_q == ROW_MAX)
                && (col_q == COL_MAX);
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int ch = 0; ch < 3; ch++) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) begin
            win_d[ch][K*i+j] = win_q[ch][K*i+j+1];
          end
        end
        // Newest column: rows r-2, r-1, r top to bottom.
        win_d[ch][K-1]    = lb1[ch];
        win_d[ch][2*K-1]  = lb0[ch];
        win_d[ch][KK-1]   = pix[ch];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign win_1     = win_q[0];
  assign win_2     = win_q[1];
  assign win_3     = win_q[2];
  assign valid_out = valid_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen.
// Per-pixel checks against hand-derived raster formula.
module tb_conv2_window_gen;
  import cnn_pkg::*;

  localparam int DB = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DB-1:0] pix_1, pix_2, pix_3;
  logic [9*DB-1:0] win_1, win_2, win_3;
  logic          valid_out, last_out;

  int n_cmp = 0;
  int n_bad = 0;
  int base  = 0;
  bit maxv  = 1'b0;
  int nwin;
  int nlast;
  logic [9*DB-1:0] hold_w1;

  always #5 clk = ~clk;

  conv2_window_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .pix_1     (pix_1),
    .pix_2     (pix_2),
    .pix_3     (pix_3),
    .win_1     (win_1),
    .win_2     (win_2),
    .win_3     (win_3),
    .valid_out (valid_out),
    .last_out  (last_out)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t pixval(int ch, int r, int c);
    int v;
    v = maxv ? 16383 : base + 12*r + c + 1000*ch;
    return pix_t'(v);
  endfunction

  function automatic logic [9*DB-1:0] exp_win(int ch, int r, int c);
    logic [9*DB-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[k*DB +: DB] = pixval(ch, r - 2 + k/3, c - 2 + k%3);
    return w;
  endfunction

  task automatic step(int r, int c);
    bit v;
    valid_in = 1'b1;
    pix_1 = pixval(0, r, c);
    pix_2 = pixval(1, r, c);
    pix_3 = pixval(2, r, c);
    @(posedge clk); #1;
    valid_in = 1'b0;
    v = (r >= 2) && (c >= 2);
    chk("valid", 128'(valid_out), 128'(v));
    chk("last", 128'(last_out), 128'(v && r == 11 && c == 11));
    if (v) begin
      chk("win1", 128'(win_1), 128'(exp_win(0, r, c)));
      chk("win2", 128'(win_2), 128'(exp_win(1, r, c)));
      chk("win3", 128'(win_3), 128'(exp_win(2, r, c)));
      nwin++;
      if (last_out) nlast++;
    end
    hold_w1 = win_1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    chk("gap_valid", 128'(valid_out), 128'(0));
    chk("gap_last", 128'(last_out), 128'(0));
    chk("gap_hold", 128'(win_1), 128'(hold_w1));
  endtask

  task automatic run_frame(int b, bit gaps, bit mx,
                           int stop_r, int stop_c);
    base  = b;
    maxv  = mx;
    nwin  = 0;
    nlast = 0;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        step(r, c);
        if (r == stop_r && c == stop_c) return;
        if (gaps) begin
          int n;
          n = $urandom_range(0, 2);
          for (int g = 0; g < n; g++) idle();
        end
      end
    end
    chk("count", 128'(nwin), 128'(100));
    chk("nlast", 128'(nlast), 128'(1));
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pix_1    = '0;
    pix_2    = '0;
    pix_3    = '0;
    hold_w1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(valid_out), 128'(0));
    chk("rst_last", 128'(last_out), 128'(0));
    chk("rst_win1", 128'(win_1), 128'(0));
    chk("rst_win3", 128'(win_3), 128'(0));
    rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b0, -1, -1);
    run_frame(0, 1'b1, 1'b0, -1, -1);
    run_frame(0, 1'b0, 1'b0, -1, -1);
    run_frame(500, 1'b0, 1'b0, -1, -1);

    run_frame(0, 1'b0, 1'b0, 5, 7);
    chk("pre_rst_valid", 128'(valid_out), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(valid_out), 128'(0));
    chk("mid_rst_last", 128'(last_out), 128'(0));
    chk("mid_rst_win1", 128'(win_1), 128'(0));
    chk("mid_rst_win2", 128'(win_2), 128'(0));
    chk("mid_rst_win3", 128'(win_3), 128'(0));
    @(posedge clk); #1;
    rst_n   = 1'b1;
    hold_w1 = win_1;
    run_frame(0, 1'b1, 1'b0, -1, -1);

    run_frame(0, 1'b0, 1'b1, -1, -1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
